// File: rtl/audio_sample_collector.sv
// Audio-clock-domain sample collector for the HDMI audio path.
// Packs stereo PCM words into up to four zero-extended 24-bit slot pairs,
// tags each slot with the IEC 60958 block-start flag and reports fill count,
// a present mask and a sticky overflow flag. The pixel domain drains the
// block by pulsing audio_buffer_rst once it has latched the outputs.
module audio_sample_collector #(
    parameter int unsigned AUDIO_BIT_WIDTH = 16,
    parameter int unsigned AUDIO_RATE      = 44100
) (
    input  logic                       clk_audio,
    input  logic                       audio_buffer_rst,
    input  logic                       audio_sample_valid,
    input  logic [AUDIO_BIT_WIDTH-1:0] audio_sample_word [1:0],
    output logic [23:0]                sample_buffer     [3:0][1:0],
    output logic [2:0]                 sample_count,
    output logic [3:0]                 sample_present,
    output logic [3:0]                 block_start,
    output logic                       overflow
);

    // Slot depth follows the audio rate: faster rates need more samples
    // per pixel-domain packet opportunity.
    localparam int unsigned MAX_SAMPLES = (AUDIO_RATE <= 48000) ? 2 :
                                          (AUDIO_RATE <= 88200) ? 3 : 4;
    localparam logic [2:0]  MAX_COUNT   = 3'(MAX_SAMPLES);
    localparam logic [7:0]  LAST_FRAME  = 8'd191;

    logic        full;
    logic        accept;
    logic [23:0] slot [MAX_SAMPLES-1:0][1:0];

    // IEC 60958 frame counter. Deliberately outside the drain reset so the
    // frame numbering runs on across buffer drains; only power-up clears it.
    logic [7:0]  frame_index = '0;

    assign full   = (sample_count >= MAX_COUNT);
    assign accept = audio_sample_valid && !audio_buffer_rst && !full;

    // Fill count, block-start tags and sticky overflow; cleared by each drain.
    always_ff @(posedge clk_audio or posedge audio_buffer_rst) begin
        if (audio_buffer_rst) begin
            sample_count <= '0;
            block_start  <= '0;
            overflow     <= 1'b0;
        end else if (audio_sample_valid) begin
            if (full) begin
                overflow <= 1'b1;
            end else begin
                sample_count <= sample_count + 3'd1;
                for (int unsigned i = 0; i < MAX_SAMPLES; i++) begin
                    if (sample_count == 3'(i)) begin
                        block_start[i] <= (frame_index == '0);
                    end
                end
            end
        end
    end

    // Slot data is not reset: stale contents are qualified by sample_present.
    always_ff @(posedge clk_audio) begin
        if (accept) begin
            for (int unsigned i = 0; i < MAX_SAMPLES; i++) begin
                if (sample_count == 3'(i)) begin
                    for (int unsigned c = 0; c < 2; c++) begin
                        slot[i][c] <= 24'(audio_sample_word[c]);
                    end
                end
            end
        end
    end

    // Frame number advances only on accepted samples, so drops and samples
    // lost under reset never consume an IEC frame number.
    always_ff @(posedge clk_audio) begin
        if (accept) begin
            frame_index <= (frame_index == LAST_FRAME) ? '0 : frame_index + 8'd1;
        end
    end

    // Present mask is a thermometer of the registered count.
    always_comb begin
        sample_present = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sample_present[i] = (sample_count > 3'(i));
        end
    end

    // Slots beyond the configured depth read as constant zero.
    for (genvar g = 0; g < 4; g++) begin : g_slot_out
        for (genvar c = 0; c < 2; c++) begin : g_chan
            if (g < MAX_SAMPLES) begin : g_live
                assign sample_buffer[g][c] = slot[g][c];
            end else begin : g_unused
                assign sample_buffer[g][c] = '0;
            end
        end
    end

endmodule

// File: tb/tb_audio_sample_collector.sv
// Directed bench for audio_sample_collector with a scoreboard queue of
// expected slot contents; three instances cover 2-, 3- and 4-slot depths.
module tb_audio_sample_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, rst_c;
    logic        va, vb, vc;
    logic [15:0] wa [1:0];
    logic [23:0] wb [1:0];
    logic [19:0] wc [1:0];
    logic [23:0] sba [3:0][1:0];
    logic [23:0] sbb [3:0][1:0];
    logic [23:0] sbc [3:0][1:0];
    logic [2:0]  cnt_a, cnt_b, cnt_c;
    logic [3:0]  pr_a, pr_b, pr_c;
    logic [3:0]  bs_a, bs_b, bs_c;
    logic        ov_a, ov_b, ov_c;

    audio_sample_collector #(.AUDIO_BIT_WIDTH(16), .AUDIO_RATE(44100)) dut_a (
        .clk_audio(clk), .audio_buffer_rst(rst_a), .audio_sample_valid(va),
        .audio_sample_word(wa), .sample_buffer(sba), .sample_count(cnt_a),
        .sample_present(pr_a), .block_start(bs_a), .overflow(ov_a));

    audio_sample_collector #(.AUDIO_BIT_WIDTH(24), .AUDIO_RATE(192000)) dut_b (
        .clk_audio(clk), .audio_buffer_rst(rst_b), .audio_sample_valid(vb),
        .audio_sample_word(wb), .sample_buffer(sbb), .sample_count(cnt_b),
        .sample_present(pr_b), .block_start(bs_b), .overflow(ov_b));

    audio_sample_collector #(.AUDIO_BIT_WIDTH(20), .AUDIO_RATE(88200)) dut_c (
        .clk_audio(clk), .audio_buffer_rst(rst_c), .audio_sample_valid(vc),
        .audio_sample_word(wc), .sample_buffer(sbc), .sample_count(cnt_c),
        .sample_present(pr_c), .block_start(bs_c), .overflow(ov_c));

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        logic        bs;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          m_cnt   [3];
    int          m_frame [3];
    logic        m_ovf   [3];
    int unsigned max_s   [3] = '{2, 4, 3};
    int unsigned width   [3] = '{16, 24, 20};

    function automatic logic [23:0] get_slot(int id, int s, int c);
        case (id)
            0:       return sba[s][c];
            1:       return sbb[s][c];
            default: return sbc[s][c];
        endcase
    endfunction

    function automatic logic [2:0] get_cnt(int id);
        case (id)
            0:       return cnt_a;
            1:       return cnt_b;
            default: return cnt_c;
        endcase
    endfunction

    function automatic logic [3:0] get_pr(int id);
        case (id)
            0:       return pr_a;
            1:       return pr_b;
            default: return pr_c;
        endcase
    endfunction

    function automatic logic [3:0] get_bs(int id);
        case (id)
            0:       return bs_a;
            1:       return bs_b;
            default: return bs_c;
        endcase
    endfunction

    function automatic logic get_ov(int id);
        case (id)
            0:       return ov_a;
            1:       return ov_b;
            default: return ov_c;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int id, input logic v, input logic [23:0] l, input logic [23:0] r);
        case (id)
            0: begin va = v; wa[0] = l[15:0]; wa[1] = r[15:0]; end
            1: begin vb = v; wb[0] = l;       wb[1] = r;       end
            default: begin vc = v; wc[0] = l[19:0]; wc[1] = r[19:0]; end
        endcase
    endtask

    task automatic set_rst(input int id, input logic v);
        case (id)
            0:       rst_a = v;
            1:       rst_b = v;
            default: rst_c = v;
        endcase
    endtask

    // Drive one valid cycle and push the expected slot into the scoreboard.
    task automatic send(input int id, input logic [23:0] l, input logic [23:0] r);
        logic [23:0] mask;
        exp_t        e;
        mask = 24'hFFFFFF >> (24 - width[id]);
        @(negedge clk);
        set_in(id, 1'b1, l, r);
        #1 chk($sformatf("dut%0d_no_comb_cnt", id), 32'(get_cnt(id)), 32'(m_cnt[id]));
        if (m_cnt[id] < int'(max_s[id])) begin
            e.l  = l & mask;
            e.r  = r & mask;
            e.bs = (m_frame[id] == 0);
            exp_q.push_back(e);
            m_cnt[id]++;
            m_frame[id] = (m_frame[id] == 191) ? 0 : m_frame[id] + 1;
        end else begin
            m_ovf[id] = 1'b1;
        end
        @(negedge clk);
        set_in(id, 1'b0, '0, '0);
    endtask

    task automatic check_state(input int id, input string tag);
        logic [3:0]  pr_exp;
        logic [3:0]  bs_exp;
        logic [23:0] v;
        pr_exp = '0;
        bs_exp = '0;
        for (int i = 0; i < 4; i++) pr_exp[i] = (m_cnt[id] > i);
        for (int i = 0; i < exp_q.size(); i++) bs_exp[i] = exp_q[i].bs;
        chk({tag, "_count"},    32'(get_cnt(id)), 32'(m_cnt[id]));
        chk({tag, "_present"},  32'(get_pr(id)),  32'(pr_exp));
        chk({tag, "_blkstart"}, 32'(get_bs(id)),  32'(bs_exp));
        chk({tag, "_overflow"}, 32'(get_ov(id)),  32'(m_ovf[id]));
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 2; c++) begin
                if (s < exp_q.size()) begin
                    v = (c == 0) ? exp_q[s].l : exp_q[s].r;
                    chk($sformatf("%s_slot%0d_%0d", tag, s, c), 32'(get_slot(id, s, c)), 32'(v));
                end else if (s >= int'(max_s[id])) begin
                    chk($sformatf("%s_slot%0d_%0d_zero", tag, s, c), 32'(get_slot(id, s, c)), 32'd0);
                end
            end
        end
    endtask

    // Check, then pulse reset inside the clock-low phase like the consumer does.
    task automatic drain(input int id, input string tag);
        check_state(id, tag);
        #1 set_rst(id, 1'b1);
        #1 chk({tag, "_drain_count"}, 32'(get_cnt(id)), 32'd0);
        chk({tag, "_drain_ovf"}, 32'(get_ov(id)), 32'd0);
        set_rst(id, 1'b0);
        exp_q.delete();
        m_cnt[id] = 0;
        m_ovf[id] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_frame[i] = 0; m_ovf[i] = 1'b0;
            set_in(i, 1'b0, '0, '0);
            set_rst(i, 1'b1);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) set_rst(i, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_state(i, $sformatf("reset%0d", i));

        // Two stereo samples into the 2-slot instance.
        send(0, 24'h001234, 24'h00ABCD);
        send(0, 24'h000001, 24'h00FFFF);
        check_state(0, "fill2");
        chk("fill2_slot0_l_const", 32'(sba[0][0]), 32'h001234);
        chk("fill2_slot1_r_const", 32'(sba[1][1]), 32'h00FFFF);
        chk("fill2_bs_const",      32'(bs_a),      32'h1);

        // Third sample while full is dropped and flags overflow.
        send(0, 24'h005555, 24'h006666);
        check_state(0, "full");
        chk("full_ovf_const", 32'(ov_a), 32'h1);
        drain(0, "full");
        send(0, 24'h000042, 24'h000043);
        check_state(0, "frame2");
        chk("frame2_bs_const", 32'(bs_a), 32'h0);

        // Asynchronous reset between edges with one slot filled.
        @(posedge clk);
        #2 set_rst(0, 1'b1);
        #1 chk("async_count",   32'(cnt_a), 32'd0);
        chk("async_present",    32'(pr_a),  32'd0);
        set_in(0, 1'b1, 24'h00DEAD, 24'h00BEEF);
        @(posedge clk);
        @(negedge clk);
        chk("valid_in_reset_count", 32'(cnt_a), 32'd0);
        set_in(0, 1'b0, '0, '0);
        set_rst(0, 1'b0);
        exp_q.delete();
        m_cnt[0] = 0;
        send(0, 24'h000777, 24'h000888);
        check_state(0, "after_async");
        drain(0, "after_async");

        // 384 samples into the 4-slot instance, drained every 4: frame wrap.
        for (int d = 0; d < 96; d++) begin
            for (int k = 0; k < 4; k++) begin
                send(1, 24'($urandom), 24'($urandom));
            end
            chk($sformatf("wrap_bs_drain%0d", d + 1), 32'(bs_b),
                (d == 0 || d == 48) ? 32'h1 : 32'h0);
            drain(1, $sformatf("wrap%0d", d + 1));
        end

        // 3-slot instance with 20-bit words: no sign extension, slot 3 zero.
        send(2, 24'h0FFFFF, 24'h012345);
        send(2, 24'h080000, 24'h000001);
        send(2, 24'h0ABCDE, 24'h0FFFFF);
        check_state(2, "max3");
        chk("max3_present_const", 32'(pr_c),      32'h7);
        chk("max3_zext_const",    32'(sbc[0][0]), 32'h0FFFFF);
        chk("max3_slot3_const",   32'(sbc[3][1]), 32'h0);
        send(2, 24'h011111, 24'h022222);
        check_state(2, "max3_ovf");
        drain(2, "max3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
